// File: rtl/soc_glip_packet_rx.sv
// soc_glip_packet_rx: GLIP receive framer.
// Strips the length header and re-emits payload with an end marker.
module soc_glip_packet_rx #(
    parameter int WIDTH   = 16,
    parameter int MAX_LEN = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      pkt_count,
    output logic             err_zero_len,
    output logic             err_oversize,
    output logic             busy
);

    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        PAYLOAD = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_LEN);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] remaining_next;

    logic in_xfer;
    logic out_xfer;
    logic hdr_zero;
    logic hdr_over;
    logic last_word;
    logic load;

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign hdr_zero  = (in_data == '0);
    assign hdr_over  = (in_data > MAX_W);
    assign last_word = (remaining == ONE_W);
    assign load      = in_xfer & (state == PAYLOAD);

    // State and word-counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HEADER;
            remaining <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
        end
    end

    // Next state: header decode, then count words down to the next header
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        unique case (state)
            HEADER: begin
                if (in_xfer && !hdr_zero) begin
                    remaining_next = in_data;
                    state_next     = hdr_over ? DRAIN : PAYLOAD;
                end
            end
            PAYLOAD, DRAIN: begin
                if (in_xfer) begin
                    remaining_next = remaining - ONE_W;
                    if (last_word) begin
                        state_next = HEADER;
                    end
                end
            end
            default: begin
                state_next     = HEADER;
                remaining_next = '0;
            end
        endcase
    end

    // State outputs: only payload forwarding is throttled by the output slot
    always_comb begin
        in_ready = 1'b1;
        busy     = (state != HEADER);
        if (state == PAYLOAD) begin
            in_ready = !out_valid | out_ready;
        end
    end

    // Output slot: loads on payload accept, empties on downstream accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= in_data;
            out_last  <= last_word;
            out_valid <= 1'b1;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    // Delivered-packet counter and registered error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count    <= '0;
            err_zero_len <= 1'b0;
            err_oversize <= 1'b0;
        end else begin
            if (out_xfer && out_last) begin
                pkt_count <= pkt_count + 16'd1;
            end
            err_zero_len <= in_xfer && (state == HEADER) && hdr_zero;
            err_oversize <= in_xfer && (state == HEADER) && hdr_over;
        end
    end

endmodule
